// File: rtl/adc_scan_pkg.sv
// Shared types and constants for the ADC0844 scan controller.
package adc_scan_pkg;

    localparam int unsigned NCH    = 4;
    localparam int unsigned CH_W   = 2;
    localparam int unsigned MA_W   = 4;
    localparam int unsigned DATA_W = 8;

    localparam logic [1:0] SE_MA_PREFIX = 2'b01;

    typedef enum logic [2:0] {
        IDLE,
        WR_LO,
        WR_HI,
        WAIT_INT,
        RD_LO,
        RD_HI,
        DONE
    } state_t;

    // Single-ended mux address for a scan channel
    function automatic logic [MA_W-1:0] se_ma(input logic [CH_W-1:0] ch);
        return {SE_MA_PREFIX, ch};
    endfunction

endpackage

// File: rtl/adc_scan_ctrl_if.sv
// CPU port of the ADC scan controller: request/ack handshake plus address and read data.
interface adc_scan_ctrl_if;
    import adc_scan_pkg::*;

    logic              cpu_req;
    logic              cpu_wr;
    logic [MA_W-1:0]   cpu_ma;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;

    modport master (
        output cpu_req, cpu_wr, cpu_ma,
        input  cpu_ack, cpu_rdata
    );

    modport slave (
        input  cpu_req, cpu_wr, cpu_ma,
        output cpu_ack, cpu_rdata
    );
endinterface

// File: rtl/adc_phase_timer.sv
// Loadable down-counter; phase_done is a registered pulse in the last clock of a
// load_val-clock interval (load_val must be >= 2).
module adc_phase_timer #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             phase_done
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt        <= '0;
            phase_done <= 1'b0;
        end else if (load) begin
            cnt        <= load_val;
            phase_done <= 1'b0;
        end else begin
            if (cnt != '0) cnt <= cnt - CNT_W'(1);
            // Registered one clock early so the consumer sees it in the final clock
            phase_done <= (cnt == CNT_W'(2));
        end
    end

endmodule

// File: rtl/adc_scan_ctrl.sv
// ADC0844 bus sequencer: round-robin channel scan arbitrated against CPU port accesses.
// Optional WAIT_INT timeout with sticky scan_err when ADC_SCAN_TIMEOUT_EN is defined.
module adc_scan_ctrl
    import adc_scan_pkg::*;
#(
    parameter int unsigned PHASE_CLKS   = 4,
    parameter int unsigned TIMEOUT_CLKS = 1023
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              scan_en,
    adc_scan_ctrl_if.slave    cpu,
    output logic [MA_W-1:0]   adc_ma,
    output logic              adc_cs_n,
    output logic              adc_wr_n,
    output logic              adc_rd_n,
    input  logic              adc_intr_n,
    input  logic [DATA_W-1:0] adc_db,
    output logic [DATA_W-1:0] ch0,
    output logic [DATA_W-1:0] ch1,
    output logic [DATA_W-1:0] ch2,
    output logic [DATA_W-1:0] ch3,
    output logic              scan_valid,
    output logic [CH_W-1:0]   scan_ch,
    output logic              scan_err
);

    localparam int unsigned TMAX  = (TIMEOUT_CLKS > PHASE_CLKS) ? TIMEOUT_CLKS : PHASE_CLKS;
    localparam int unsigned CNT_W = $clog2(TMAX + 1);

    state_t            state;
    logic              owner_scan;
    logic              kind_wr;
    logic [CH_W-1:0]   ch_ptr;
    logic [DATA_W-1:0] sample;
    logic [DATA_W-1:0] ch_res [NCH];

    logic              phase_done;
    logic              grant_cpu_c;
    logic              leave_c;
    logic [CNT_W-1:0]  load_val_c;

`ifdef ADC_SCAN_TIMEOUT_EN
    logic              timed_out;
`else
    assign scan_err = 1'b0;
`endif

    assign ch0 = ch_res[0];
    assign ch1 = ch_res[1];
    assign ch2 = ch_res[2];
    assign ch3 = ch_res[3];

    // Timer reloads on every state exit; the ack term blocks a re-grant while the CPU drops req
    always_comb begin
        grant_cpu_c = cpu.cpu_req && !cpu.cpu_ack;
        leave_c     = 1'b0;
        load_val_c  = CNT_W'(PHASE_CLKS);
        case (state)
            IDLE:                      leave_c = grant_cpu_c || scan_en;
            WR_LO, WR_HI, RD_LO, RD_HI: leave_c = phase_done;
            WAIT_INT: begin
                leave_c = !adc_intr_n;
`ifdef ADC_SCAN_TIMEOUT_EN
                if (phase_done) leave_c = 1'b1;
`endif
            end
            DONE:                      leave_c = 1'b1;
            default:                   leave_c = 1'b0;
        endcase
`ifdef ADC_SCAN_TIMEOUT_EN
        if (state == WR_HI && owner_scan) load_val_c = CNT_W'(TIMEOUT_CLKS);
`endif
    end

    adc_phase_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (leave_c),
        .load_val   (load_val_c),
        .phase_done (phase_done)
    );

    // Sequencer FSM with registered strobes, pulses and result registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            owner_scan    <= 1'b0;
            kind_wr       <= 1'b0;
            ch_ptr        <= '0;
            sample        <= '0;
            adc_ma        <= '0;
            adc_cs_n      <= 1'b1;
            adc_wr_n      <= 1'b1;
            adc_rd_n      <= 1'b1;
            cpu.cpu_ack   <= 1'b0;
            cpu.cpu_rdata <= '0;
            scan_valid    <= 1'b0;
            scan_ch       <= '0;
            for (int i = 0; i < NCH; i++) ch_res[i] <= '0;
`ifdef ADC_SCAN_TIMEOUT_EN
            timed_out     <= 1'b0;
            scan_err      <= 1'b0;
`endif
        end else begin
            cpu.cpu_ack <= 1'b0;
            scan_valid  <= 1'b0;
            case (state)
                IDLE: begin
`ifdef ADC_SCAN_TIMEOUT_EN
                    if (leave_c) timed_out <= 1'b0;
`endif
                    if (grant_cpu_c) begin
                        owner_scan <= 1'b0;
                        kind_wr    <= cpu.cpu_wr;
                        adc_cs_n   <= 1'b0;
                        if (cpu.cpu_wr) begin
                            adc_ma   <= cpu.cpu_ma;
                            adc_wr_n <= 1'b0;
                            state    <= WR_LO;
                        end else begin
                            adc_rd_n <= 1'b0;
                            state    <= RD_LO;
                        end
                    end else if (scan_en) begin
                        owner_scan <= 1'b1;
                        kind_wr    <= 1'b1;
                        adc_ma     <= se_ma(ch_ptr);
                        adc_cs_n   <= 1'b0;
                        adc_wr_n   <= 1'b0;
                        state      <= WR_LO;
                    end
                end
                WR_LO: if (phase_done) begin
                    adc_cs_n <= 1'b1;
                    adc_wr_n <= 1'b1;
                    state    <= WR_HI;
                end
                WR_HI: if (phase_done) state <= owner_scan ? WAIT_INT : DONE;
                WAIT_INT: begin
                    if (!adc_intr_n) begin
                        adc_cs_n <= 1'b0;
                        adc_rd_n <= 1'b0;
                        state    <= RD_LO;
                    end
`ifdef ADC_SCAN_TIMEOUT_EN
                    else if (phase_done) begin
                        timed_out <= 1'b1;
                        scan_err  <= 1'b1;
                        state     <= DONE;
                    end
`endif
                end
                RD_LO: if (phase_done) begin
                    sample   <= adc_db;
                    adc_cs_n <= 1'b1;
                    adc_rd_n <= 1'b1;
                    state    <= RD_HI;
                end
                RD_HI: if (phase_done) state <= DONE;
                DONE: begin
                    state <= IDLE;
                    if (owner_scan) begin
`ifdef ADC_SCAN_TIMEOUT_EN
                        if (!timed_out)
`endif
                        begin
                            ch_res[ch_ptr] <= sample;
                            scan_valid     <= 1'b1;
                            scan_ch        <= ch_ptr;
                        end
                        ch_ptr <= ch_ptr + CH_W'(1);
                    end else begin
                        cpu.cpu_ack <= 1'b1;
                        if (!kind_wr) cpu.cpu_rdata <= sample;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_scan_ctrl.sv
// Directed bench for adc_scan_ctrl with an ADC0844 behavioural model and scan/CPU scoreboards.
// Timeout scenario compiles in only when ADC_SCAN_TIMEOUT_EN is defined.
module tb_adc_scan_ctrl;

    typedef struct packed {
        logic [1:0] ch;
        logic [7:0] data;
    } scan_exp_t;

    logic       clk;
    logic       reset_n;
    logic       scan_en;
    logic [3:0] adc_ma;
    logic       adc_cs_n, adc_wr_n, adc_rd_n;
    logic       adc_intr_n;
    logic [7:0] adc_db;
    logic [7:0] ch0, ch1, ch2, ch3;
    logic       scan_valid;
    logic [1:0] scan_ch;
    logic       scan_err;

    adc_scan_ctrl_if cpu_bus ();

    adc_scan_ctrl #(
        .PHASE_CLKS   (4),
        .TIMEOUT_CLKS (16)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .scan_en    (scan_en),
        .cpu        (cpu_bus),
        .adc_ma     (adc_ma),
        .adc_cs_n   (adc_cs_n),
        .adc_wr_n   (adc_wr_n),
        .adc_rd_n   (adc_rd_n),
        .adc_intr_n (adc_intr_n),
        .adc_db     (adc_db),
        .ch0        (ch0),
        .ch1        (ch1),
        .ch2        (ch2),
        .ch3        (ch3),
        .scan_valid (scan_valid),
        .scan_ch    (scan_ch),
        .scan_err   (scan_err)
    );

    int        n_checks = 0;
    int        n_err    = 0;
    scan_exp_t scan_q[$];
    logic [7:0] cpu_q[$];
    logic      intr_enable = 1'b1;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic fail_now(input string tag, input logic [31:0] obs);
        n_checks++;
        n_err++;
        $error("FAIL %s: observed=0x%0h expected=event_within_budget", tag, obs);
    endtask

    function automatic logic [7:0] ch_val(input logic [1:0] c);
        case (c)
            2'd0:    return ch0;
            2'd1:    return ch1;
            2'd2:    return ch2;
            default: return ch3;
        endcase
    endfunction

    // ADC0844 model: a wr pulse starts a conversion, intr falls 5 clocks after wr_n rises, rd clears it
    initial begin
        int conv_cnt;
        conv_cnt   = 0;
        adc_intr_n = 1'b1;
        adc_db     = 8'h00;
        forever begin
            @(negedge clk);
            adc_db = (adc_ma[3:2] == 2'b01) ? (8'h40 + {6'b0, adc_ma[1:0]}) : 8'hA5;
            if (adc_wr_n === 1'b0) begin
                conv_cnt   = 5;
                adc_intr_n = 1'b1;
            end else if (adc_rd_n === 1'b0) begin
                conv_cnt   = 0;
                adc_intr_n = 1'b1;
            end else if (conv_cnt != 0) begin
                conv_cnt--;
                if (conv_cnt == 0 && intr_enable) adc_intr_n = 1'b0;
            end
        end
    end

    // Scan scoreboard: every scan_valid pulse must match the oldest pushed expectation
    initial begin
        scan_exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (scan_valid === 1'b1) begin
                if (scan_q.size() == 0) begin
                    fail_now("scan_unexpected", {30'b0, scan_ch});
                end else begin
                    e = scan_q.pop_front();
                    check("scan_ch", {30'b0, scan_ch}, {30'b0, e.ch});
                    check("scan_data", {24'b0, ch_val(e.ch)}, {24'b0, e.data});
                    check("scan_ma", {28'b0, adc_ma}, {28'b0, 2'b01, e.ch});
                end
            end
        end
    end

    task automatic push_scan(input logic [1:0] c);
        scan_exp_t e;
        e.ch   = c;
        e.data = 8'h40 + {6'b0, c};
        scan_q.push_back(e);
    endtask

    task automatic drain_scans(input string tag, input int budget);
        int n = 0;
        while (scan_q.size() != 0 && n < budget) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (scan_q.size() != 0) begin
            fail_now(tag, scan_q.size());
            scan_q.delete();
        end
    endtask

    // One CPU access; latency counted in clocks from the request edge to the visible ack
    task automatic cpu_access(input logic wr, input logic [3:0] ma, input logic with_scan);
        int         n = 0;
        int         lo = 0;
        logic [3:0] ma_seen = 4'h0;
        logic [7:0] exp_d;
        @(posedge clk);
        #1;
        cpu_bus.cpu_req = 1'b1;
        cpu_bus.cpu_wr  = wr;
        cpu_bus.cpu_ma  = ma;
        if (with_scan) scan_en = 1'b1;
        if (!wr) cpu_q.push_back(8'hA5);
        while (cpu_bus.cpu_ack !== 1'b1 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
            if ((wr ? adc_wr_n : adc_rd_n) === 1'b0) begin
                lo++;
                ma_seen = adc_ma;
            end
        end
        cpu_bus.cpu_req = 1'b0;
        if (cpu_bus.cpu_ack !== 1'b1) begin
            fail_now(wr ? "cpu_wr_ack_timeout" : "cpu_rd_ack_timeout", n);
        end else begin
            check(wr ? "cpu_wr_latency" : "cpu_rd_latency", n, 10);
            check(wr ? "cpu_wr_strobe_clks" : "cpu_rd_strobe_clks", lo, 4);
            if (wr) check("cpu_wr_ma", {28'b0, ma_seen}, {28'b0, ma});
            if (!wr && cpu_q.size() != 0) begin
                exp_d = cpu_q.pop_front();
                check("cpu_rdata", {24'b0, cpu_bus.cpu_rdata}, {24'b0, exp_d});
            end
        end
    endtask

    initial begin
        int n;
        reset_n         = 1'b0;
        scan_en         = 1'b0;
        cpu_bus.cpu_req = 1'b0;
        cpu_bus.cpu_wr  = 1'b0;
        cpu_bus.cpu_ma  = 4'h0;

        // Reset values
        #12;
        check("rst_cs_n", {31'b0, adc_cs_n}, 1);
        check("rst_wr_n", {31'b0, adc_wr_n}, 1);
        check("rst_rd_n", {31'b0, adc_rd_n}, 1);
        check("rst_ma", {28'b0, adc_ma}, 0);
        check("rst_ch", {ch0, ch1, ch2, ch3}, 0);
        check("rst_rdata", {24'b0, cpu_bus.cpu_rdata}, 0);
        check("rst_pulses", {29'b0, cpu_bus.cpu_ack, scan_valid, scan_err}, 0);
        check("rst_scan_ch", {30'b0, scan_ch}, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // Full round-robin scan including wrap back to channel 0
        for (int c = 0; c < 5; c++) push_scan(2'(c % 4));
        scan_en = 1'b1;
        drain_scans("scan_round_timeout", 400);
        scan_en = 1'b0;
        check("ch0_final", {24'b0, ch0}, 32'h40);
        check("ch1_final", {24'b0, ch1}, 32'h41);
        check("ch2_final", {24'b0, ch2}, 32'h42);
        check("ch3_final", {24'b0, ch3}, 32'h43);
        repeat (3) @(posedge clk);

        // CPU mux-address write
        cpu_access(1'b1, 4'b1100, 1'b0);
        repeat (3) @(posedge clk);

        // CPU read and scan request together: CPU first, scan WR_LO right after the ack clock
        push_scan(2'd1);
        cpu_access(1'b0, 4'h0, 1'b1);
        check("cont_idle_wr_n", {31'b0, adc_wr_n}, 1);
        @(posedge clk);
        #1;
        check("cont_scan_wr_n", {31'b0, adc_wr_n}, 0);
        check("cont_scan_cs_n", {31'b0, adc_cs_n}, 0);
        check("cont_scan_ma", {28'b0, adc_ma}, 32'b0101);
        drain_scans("cont_scan_timeout", 100);
        scan_en = 1'b0;
        repeat (3) @(posedge clk);

        // Reset during RD_LO: strobes and results clear without a clock edge
        scan_en = 1'b1;
        n = 0;
        while (adc_rd_n !== 1'b0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (adc_rd_n !== 1'b0) fail_now("rd_lo_timeout", n);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("async_cs_n", {31'b0, adc_cs_n}, 1);
        check("async_rd_n", {31'b0, adc_rd_n}, 1);
        check("async_wr_n", {31'b0, adc_wr_n}, 1);
        check("async_ch01", {16'b0, ch0, ch1}, 0);
        @(negedge clk);
        reset_n = 1'b1;
        push_scan(2'd0);
        drain_scans("post_reset_scan_timeout", 100);
        scan_en = 1'b0;
        repeat (3) @(posedge clk);

`ifdef ADC_SCAN_TIMEOUT_EN
        // No interrupt: 16 clocks in WAIT_INT then scan_err, no result, channel advances
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n     = 1'b1;
        intr_enable = 1'b0;
        scan_en     = 1'b1;
        n = 0;
        while (adc_wr_n !== 1'b0 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        n = 0;
        while (adc_wr_n !== 1'b1 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        n = 0;
        while (scan_err !== 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        scan_en = 1'b0;
        if (scan_err !== 1'b1) fail_now("scan_err_timeout", n);
        else check("timeout_clks", n, 4 + 16);
        check("timeout_ch0", {24'b0, ch0}, 0);
        repeat (4) @(posedge clk);
        intr_enable = 1'b1;
        push_scan(2'd1);
        scan_en = 1'b1;
        drain_scans("after_timeout_scan_timeout", 100);
        scan_en = 1'b0;
        check("scan_err_sticky", {31'b0, scan_err}, 1);
        repeat (3) @(posedge clk);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/adc_scan_ctrl.md
# adc_scan_ctrl

Bus sequencer for the ADC0844 joystick converter. It scans the four analog channels round-robin and keeps the latest result per channel in registers. It also arbitrates the single ADC bus between this autonomous scan and CPU port accesses. It sits between the CPU I/O decode and the ADC.

## Interface
Parameters:
- `PHASE_CLKS`, default 4: clocks each strobe phase (cs/wr/rd low or high) is held; must be ≥2.
- `TIMEOUT_CLKS`, default 1023: clocks to wait for `adc_intr_n` low; used only with the macro below.

Ports:
- `clk` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `scan_en` in 1: enables the autonomous channel scan.
- `cpu_req` in 1: CPU access request, held until `cpu_ack`.
- `cpu_wr` in 1: 1 = mux-address write (start conversion), 0 = data read.
- `cpu_ma` in 4: mux address for a CPU write.
- `cpu_ack` out 1: one-clock completion pulse.
- `cpu_rdata` out 8: data from the last CPU read, valid with `cpu_ack`.
- `adc_ma` out 4: ADC mux address.
- `adc_cs_n`, `adc_wr_n`, `adc_rd_n` out 1 each: ADC strobes.
- `adc_intr_n` in 1: ADC conversion-done flag.
- `adc_db` in 8: ADC data bus.
- `ch0..ch3` out 8 each: latest scan result per channel.
- `scan_valid` out 1: one-clock pulse on each result update.
- `scan_ch` out 2: channel updated by the current `scan_valid` pulse.
- `scan_err` out 1: sticky timeout flag; cleared only by reset (macro builds only).

## Operation
- States: `IDLE`, `WR_LO`, `WR_HI`, `WAIT_INT`, `RD_LO`, `RD_HI`, `DONE`.
- Arbitration is evaluated in `IDLE` only. `cpu_req` has priority over a scan; a scan starts when `scan_en` is high and no `cpu_req` is pending.
- Owner and kind are latched at grant. No preemption; the other requester waits.
- Scan cycle:
  - `adc_ma = {2'b01, ch}` (single-ended channel) throughout.
  - `WR_LO`: `cs_n=0`, `wr_n=0`.
  - `WR_HI`: `wr_n=1`, `cs_n` released.
  - `WAIT_INT` until `adc_intr_n==0`.
  - `RD_LO`: `cs_n=0`, `rd_n=0`; `adc_db` is sampled on the last clock of `RD_LO`.
  - `RD_HI`: strobes released.
  - `DONE`: write `ch[ch]`, pulse `scan_valid`, `ch <= ch+1` (wraps 3→0).
- CPU write: `WR_LO`, `WR_HI`, then `DONE` with `cpu_ack`. No wait for `adc_intr_n`.
- CPU read: `RD_LO`, `RD_HI`, then `DONE` with `cpu_ack` and `cpu_rdata = sampled adc_db`.
- A CPU write changes the ADC mux; the next scan rewrites its own address, so scan results are never corrupted by CPU activity.
- `scan_en` falling while `WAIT_INT`: complete the read anyway; never abandon a started conversion (in macro builds the timeout also applies).
- `scan_en` low in `IDLE`: no scan starts. Channel pointer and results are retained.

## Timing
- Each strobe state lasts exactly `PHASE_CLKS` clocks; `DONE` lasts 1 clock and then returns to `IDLE`.
- `IDLE`→grant takes 1 clock.
- CPU write latency, `cpu_req` high to `cpu_ack`: 1 + 2·`PHASE_CLKS` + 1 clocks (10 at default).
- CPU read latency is the same, 10 clocks at default.
- Scan cycle: 1 + 4·`PHASE_CLKS` + wait + 1 clocks.
- `adc_intr_n` is sampled directly each clock, with no synchronizer (same clock domain); the transition out of `WAIT_INT` is taken on the first clock it is seen low.
- Reset values:
  - `adc_cs_n`, `adc_wr_n`, `adc_rd_n` = 1.
  - `adc_ma`, `ch0..ch3`, `cpu_rdata`, `scan_ch` = 0.
  - `cpu_ack`, `scan_valid`, `scan_err` = 0.
  - Channel pointer = 0; state = `IDLE`.
- Reset asserted mid-cycle: strobes go high immediately (asynchronously), the cycle is dropped, and no ack is issued.
- `cpu_req` and `scan_en` rising on the same clock in `IDLE`: CPU wins, scan starts after `DONE`.

## Configuration
- Macro: `ADC_SCAN_TIMEOUT_EN`.
- Defined: a counter runs in `WAIT_INT`. After `TIMEOUT_CLKS` clocks without `adc_intr_n` low:
  - set `scan_err`;
  - skip the read and go to `DONE`;
  - advance the channel with the `ch` register unchanged and no `scan_valid`.
- Undefined: `WAIT_INT` waits indefinitely; `scan_err` is tied to 0 and the counter is absent.

## Structure
- Package `adc_scan_pkg`:
  - state enum;
  - `SE_MA_PREFIX = 2'b01`;
  - channel count `NCH = 4`.
- Sub-module `adc_phase_timer`: loadable down-counter producing a `phase_done` pulse after `PHASE_CLKS`; reused for the timeout count in macro builds.
- Top level: FSM, arbiter, and result registers.

## Test plan
- **Scan with prompt interrupt:** `scan_en=1`, ADC model asserts intr 5 clocks after `wr_n` rises, returns 0x40+ch. Expect `ch0..ch3` = 0x40..0x43 and `scan_ch` sequence 0,1,2,3,0. Expect `adc_ma` = 4'b0100..4'b0111.
- **CPU write:** `cpu_req`, `cpu_wr=1`, `cpu_ma=4'b1100` in `IDLE`. Expect `wr_n` low 4 clocks with `adc_ma=4'b1100`, and `cpu_ack` 10 clocks after the request.
- **Contention:** `cpu_req` (read) and `scan_en` rise together. CPU cycle first, with `cpu_rdata` = model's `adc_db` (0xA5); the scan `WR_LO` begins the clock after `cpu_ack`.
- **Timeout (`ADC_SCAN_TIMEOUT_EN`, `TIMEOUT_CLKS=16`):** intr never asserts. `scan_err` = 1 after 16 clocks in `WAIT_INT`, `ch0` unchanged, channel advances to 1, no `scan_valid`.
- **Reset mid-read:** `reset_n` low during `RD_LO`. All strobes = 1 and `ch*` = 0 within the same clock (asynchronous); after release, a scan resumes at channel 0.
